// File: rtl/mem_stream_reader.sv
// Streams a contiguous, wrapping block of synchronous-RAM words out over a
// valid/ready interface, keeping reads in flight plus buffered words within a 2-entry FIFO.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | reads remaining to issue
// DRAIN | all reads issued, words still outstanding
module mem_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  in_flight;
  logic                  in_flight_last;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;

  logic       accept;
  logic       issue;
  logic       issue_last;
  logic       push;
  logic       pop;
  logic [2:0] occupancy;

  // Handshake and FIFO status
  assign accept    = (state == IDLE) && cmd_valid;
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = in_flight;
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];
  assign busy      = (state != IDLE);

  // A word popped this cycle frees its slot in time for a read issued now.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, in_flight};
  assign issue      = (state == RUN) && (occupancy < (3'd2 + {2'b00, pop}));
  assign issue_last = issue && (remaining == REM_ONE);

  assign mem_addr = issue ? addr_q : addr_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    mem_en    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        mem_en = issue;
        if (issue_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address / remaining-count tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      addr_hold <= '0;
      remaining <= '0;
    end else if (accept) begin
      addr_q    <= cmd_addr;
      remaining <= {1'b0, cmd_len} + REM_ONE;
    end else if (issue) begin
      addr_q    <= addr_q + ADDR_ONE;
      addr_hold <= addr_q;
      remaining <= remaining - REM_ONE;
    end
  end

  // Clearing in_flight on reset is what discards data from a pre-reset read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight      <= issue;
      in_flight_last <= issue_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= 2'b00;
      wr_ptr       <= 1'b0;
    end else if (push) begin
      fifo_data[wr_ptr] <= mem_dout;
      fifo_last[wr_ptr] <= in_flight_last;
      wr_ptr            <= ~wr_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized bench for mem_stream_reader: a RAM model plus a queue of the
// words each command must produce, checked on the falling edge.
module tb_mem_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       mem_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_dout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  mem_stream_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (mem_en) mem_dout <= ram[mem_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference state for the running transfer
  int         exp_q[$];
  int         exp_base;
  int         issued;
  int         popped;
  int         last_addr;
  bit         mon_en;
  bit         xfer_done;
  bit         prev_hold;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (mem_en) begin
        chk("mem_addr", mem_addr, (exp_base + issued) % 16);
        last_addr = mem_addr;
        issued++;
      end else begin
        chk("addr_hold", mem_addr, last_addr);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", 1, 0);
        end else begin
          int w;
          w = exp_q.pop_front();
          chk("out_data", out_data, w);
          chk("out_last", out_last, (exp_q.size() == 0));
          if (exp_q.size() == 0) xfer_done = 1'b1;
        end
        popped++;
      end
      chk("occupancy_le_2", ((issued - popped) <= 2), 1);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  function automatic logic ready_fn(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2 == 0);
      2:       return 1'($urandom_range(0, 1));
      default: return (cyc >= 10);
    endcase
  endfunction

  // mode: 0 ready held, 1 toggling, 2 random, 3 held low 10 cycles
  task automatic run_cmd(input int a, input int l, input int mode, input bit inject,
                         input int rst_at);
    int cyc;
    exp_q.delete();
    for (int i = 0; i <= l; i++) exp_q.push_back(ram[(a + i) % 16]);
    exp_base  = a;
    issued    = 0;
    popped    = 0;
    xfer_done = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = a[3:0];
    cmd_len   = l[3:0];
    out_ready = ready_fn(mode, 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    while (1) begin
      if (mode == 3 && cyc == 10) chk("held_issues", issued, 2);
      out_ready = ready_fn(mode, cyc);
      if (inject && cyc == 2) begin
        cmd_valid = 1'b1;
        cmd_addr  = 4'(a + 8);
        cmd_len   = 4'(l + 3);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) begin
        chk("lat_mem_en", mem_en, 1);
        chk("lat_busy", busy, 1);
        chk("lat_cmd_ready", cmd_ready, 0);
      end
      if (cyc == 1) chk("lat_t2_valid", out_valid, 0);
      if (cyc == 2) chk("lat_t3_valid", out_valid, 1);
      if (inject && cyc == 2) chk("inject_cmd_ready", cmd_ready, 0);
      @(posedge clk);
      #1;
      cyc++;
      if (rst_at > 0 && popped == rst_at) begin
        rst_n  = 1'b0;
        mon_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        last_addr = 0;
        check_idle("abort");
        mon_en = 1'b1;
        return;
      end
      if (xfer_done) break;
      if (cyc >= 400) begin
        chk("transfer_timeout", 1, 0);
        break;
      end
    end
    cmd_valid = 1'b0;
    chk("done_cmd_ready", cmd_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    mon_en    = 1'b0;
    last_addr = 0;
    for (int k = 0; k < 16; k++) ram[k] = 8'(3 * k);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle("reset");
    mon_en = 1'b1;

    run_cmd(2, 3, 0, 0, 0);
    run_cmd(14, 3, 0, 0, 0);

    for (int k = 0; k < 16; k++) ram[k] = 8'($urandom);
    run_cmd(int'($urandom_range(0, 15)), 7, 1, 0, 0);
    run_cmd(int'($urandom_range(0, 15)), 5, 3, 0, 0);
    run_cmd(5, 6, 1, 1, 0);
    run_cmd(0, 15, 2, 0, 0);

    ram[0] = 8'hA5;
    run_cmd(3, 7, 0, 0, 2);
    run_cmd(0, 0, 0, 0, 0);

    for (int t = 0; t < 20; t++) begin
      if (t % 5 == 0) begin
        for (int k = 0; k < 16; k++) ram[k] = 8'($urandom);
      end
      run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4: memory address width; transfers wrap modulo 2^ADDR_WIDTH.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: memory word and stream data width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_addr  in  ADDR_WIDTH  start address.
REQ-008 cmd_len  in  ADDR_WIDTH  word count minus 1 (0 = 1 word).
REQ-009 mem_en  out  1  synchronous-RAM read strobe.
REQ-010 mem_addr  out  ADDR_WIDTH  read address.
REQ-011 mem_dout  in  DATA_WIDTH  RAM data, valid exactly 1 cycle after mem_en.
REQ-012 out_valid  out  1  stream word valid.
REQ-013 out_ready  in  1  downstream accepts word.
REQ-014 out_data  out  DATA_WIDTH  stream word.
REQ-015 out_last  out  1  marks final word of a transfer; qualified by out_valid.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, RUN (reads remaining to issue) and DRAIN (all reads issued, words outstanding).
REQ-018 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-019 On accept: latch addr/len, set remaining = cmd_len+1, IDLE->RUN.
REQ-020 Output buffer SHALL be a 2-entry FIFO; in_flight (0/1) SHALL count reads issued last cycle.
REQ-021 In RUN, mem_en SHALL be 1 iff fifo_count + in_flight - pop < 2, where pop = out_valid && out_ready.
REQ-022 Each issue SHALL drive mem_addr = current address, then increment address modulo 2^ADDR_WIDTH (14,15,0,1 wrap).
REQ-023 When the last read issues, RUN->DRAIN on the next edge.
REQ-024 mem_dout SHALL be pushed into the FIFO on the cycle after each mem_en; never dropped, never duplicated.
REQ-025 Latency: command accepted at edge T -> mem_en in cycle T+1 -> out_valid in cycle T+3.
REQ-026 With out_ready held 1, words SHALL stream one per cycle with no bubbles after the first.
REQ-027 out_valid = FIFO non-empty; out_data/out_last SHALL be stable while out_valid && !out_ready.
REQ-028 out_last SHALL be 1 only on word number cmd_len+1; cmd_len=0 yields out_last on the first word.
REQ-029 DRAIN->IDLE on the edge where the out_last word is handshaken; cmd_ready SHALL be 1 the following cycle.
REQ-030 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-031 When not issuing, mem_en SHALL be 0 and mem_addr SHALL hold its last value.

Reset
REQ-032 On a clk edge with rst_n=0: state=IDLE, FIFO emptied, in_flight=0, address/remaining=0.
REQ-033 After that edge: out_valid=0, out_last=0, out_data=0, mem_en=0, mem_addr=0, busy=0, cmd_ready=1.
REQ-034 Reset mid-transfer SHALL abort it; mem_dout returning from a pre-reset read SHALL be discarded.

Verification
REQ-035 RAM[k]=3k, cmd addr=2 len=3, out_ready=1 -> out_data 6,9,12,15 on consecutive cycles, first at T+3, out_last on 15, cmd_ready=1 next cycle.
REQ-036 addr=14 len=3 -> mem_addr sequence 14,15,0,1; data RAM[14],RAM[15],RAM[0],RAM[1].
REQ-037 len=7, out_ready toggling 1,0,1,0 -> all 8 words in order, no loss/duplication, fifo_count+in_flight never exceeds 2.
REQ-038 out_ready=0 for 10 cycles after accept -> exactly 2 mem_en pulses, out_data stable, then full transfer completes on release.
REQ-039 rst_n=0 for 1 cycle after 2 of 8 words -> out_valid=0, cmd_ready=1; next command addr=0 len=0 -> single word RAM[0] with out_last=1, no stale data.
REQ-040 cmd_valid pulsed during RUN with different addr -> ignored; current transfer data unchanged.
